prime_scanner: RTL and testbench

PRIME_SCANNER -- requirements
Module: prime_scanner

---
 rtl/prime_scanner_pkg.sv | 15 +
 rtl/prime_scanner_if.sv | 24 ++
 rtl/prime_fifo2.sv | 44 ++++
 rtl/prime_scanner.sv | 120 ++++++++++++
 tb/tb_prime_scanner.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/prime_scanner_pkg.sv
// Shared constants and FSM encoding for the prime scanner
// and the upstream sieve stage.
package prime_scanner_pkg;

  localparam int N_DEF  = 1000000;
  localparam int AW_DEF = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/prime_scanner_if.sv
// Prime output handshake: valid/ready with a prime value.
interface prime_scanner_if
  import prime_scanner_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic          p_valid;
  logic          p_ready;
  logic [AW-1:0] p_data;

  modport master (
    output p_valid,
    output p_data,
    input  p_ready
  );

  modport slave (
    input  p_valid,
    input  p_data,
    output p_ready
  );

endinterface

// File: rtl/prime_fifo2.sv
// Two-entry FIFO holding primes returned from the bitmap.
module prime_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp    <= wp ^ push;
      rp    <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rp];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/prime_scanner.sv
// Walks the sieve bitmap from 2 to N-1 and hands every
// prime downstream in ascending order.
module prime_scanner
  import prime_scanner_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic [AW-1:0]   rd_addr,
  input  logic            rd_data,
  prime_scanner_if.master prime,
  output logic [AW-1:0]   count,
  output logic            busy,
  output logic            done
);

  localparam logic [AW-1:0] FIRST = AW'(2);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW-1:0] ONE   = AW'(1);

  scan_state_t   state;
  scan_state_t   state_nx;
  logic          issue;
  logic          launch;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [1:0]    fcnt;
  logic [1:0]    slots;
  logic [AW-1:0] tag;
  logic          tag_v;
  logic [AW-1:0] head;

  assign pop  = prime.p_valid & prime.p_ready;
  assign push = tag_v & rd_data;

  // Credit after this cycle's pop: a read in flight reserves a slot.
  assign slots = fcnt - {1'b0, pop} + {1'b0, tag_v};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    launch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          launch   = 1'b1;
        end
      end
      SCAN: begin
        issue = ~slots[1] & ~full;
        if (issue && rd_addr == LAST)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!tag_v && empty)
          state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          state_nx = SCAN;
          launch   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr <= '0;
      tag     <= '0;
      tag_v   <= 1'b0;
      count   <= '0;
    end else begin
      tag_v <= issue;
      if (issue) tag <= rd_addr;
      if (launch) begin
        rd_addr <= FIRST;
        count   <= '0;
      end else begin
        if (issue && rd_addr != LAST)
          rd_addr <= rd_addr + ONE;
        if (pop)
          count <= count + ONE;
      end
    end
  end

  prime_fifo2 #(
    .W (AW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (launch),
    .push  (push),
    .din   (tag),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  assign prime.p_valid = ~empty;
  assign prime.p_data  = head;
  assign busy = (state == SCAN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_prime_scanner.sv
// Directed bench for prime_scanner with a trial-division
// reference model and a per-cycle handshake scoreboard.
module tb_prime_scanner;

  localparam int N  = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          rd_data = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;

  prime_scanner_if #(.AW(AW)) pif ();

  prime_scanner #(
    .N  (N),
    .AW (AW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .prime   (pif),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  bit            bm [32];
  int            exp_q [$];
  int            errors = 0;
  int            checks = 0;
  int            xfers = 0;
  int            last_p = 0;
  int            mode = 0;
  int            ph = 0;
  bit            chk_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_data = '0;

  // Bitmap RAM read port with one cycle of latency.
  always @(posedge clk) rd_data <= bm[rd_addr];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 pattern.
  initial begin
    pif.p_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) begin
        pif.p_ready = 1'b1;
      end else begin
        pif.p_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("count", count, xfers);
        if (done) chk("valid_in_done", pif.p_valid, 0);
        if (prev_stall) begin
          chk("stall_valid", pif.p_valid, 1);
          chk("stall_data", pif.p_data, prev_data);
        end
        if (pif.p_valid && pif.p_ready) begin
          if (xfers < exp_q.size())
            chk("p_data", pif.p_data, exp_q[xfers]);
          else
            chk("extra_prime", xfers, exp_q.size());
          chk("ascending", int'(pif.p_data) > last_p, 1);
          last_p = int'(pif.p_data);
          xfers++;
        end
        prev_stall = pif.p_valid && !pif.p_ready;
        prev_data  = pif.p_data;
      end
    end
  end

  task automatic begin_scan();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    xfers = 0;
    last_p = 0;
    prev_stall = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run_scan(input bit midstart, input bit timed);
    int n;
    n = 0;
    begin_scan();
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("first_addr", rd_addr, 2);
        chk("busy_scan", busy, 1);
      end
      if (n == 2) chk("lat_not_yet", pif.p_valid, 0);
      if (n == 3) begin
        chk("lat_valid", pif.p_valid, 1);
        chk("lat_data", pif.p_data, 2);
      end
      if (midstart && n == 5) start = 1'b1;
      if (midstart && n == 6) start = 1'b0;
    end while (!done && n < 300);
    chk("done_seen", done, 1);
    if (timed) chk("done_cycle", n, 22);
    chk("final_count", count, 8);
    chk("final_xfers", xfers, exp_q.size());
    chk("busy_in_done", busy, 0);
    chk("last_addr", rd_addr, N - 1);
    repeat (3) @(negedge clk);
    chk("addr_hold", rd_addr, N - 1);
    chk("done_hold", done, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_p_valid"}, pif.p_valid, 0);
    chk({tag, "_p_data"}, pif.p_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int k;
    bit isp;
    for (int v = 2; v < N; v++) begin
      isp = 1'b1;
      for (int d = 2; d * d <= v; d++)
        if (v % d == 0) isp = 1'b0;
      bm[v] = isp;
      if (isp) exp_q.push_back(v);
    end
    chk("model_size", exp_q.size(), 8);
    chk("model_last", exp_q[exp_q.size() - 1], 19);

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle");

    mode = 0;
    run_scan(1'b0, 1'b1);

    ph = 0;
    mode = 1;
    run_scan(1'b0, 1'b0);
    mode = 0;

    run_scan(1'b1, 1'b1);

    begin_scan();
    k = 0;
    while (xfers < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("third_accepted", xfers, 3);
    #2;
    chk("count_before_rst", count, 3);
    chk_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("post_rst");

    run_scan(1'b0, 1'b1);
    run_scan(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
